led_display_pattern_gen_multi: RTL and testbench

Parametrised multi-mode test-pattern source for the LED matrix display path. Generates one full frame of RGB pixels in raster order and streams them to the display driver over a valid/ready handshake. Generalises the single-pattern generator to arbitrary panel size, colour depth and five selectable patterns, including an animated one. Sits between the control/register block and the display driver/frame RAM writer.

---
 rtl/led_display_pattern_gen_multi.sv | 171 +++++++++++++++++
 tb/tb_led_display_pattern_gen_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_display_pattern_gen_multi.sv
// Multi-mode LED matrix test-pattern source.
// Streams one raster-order RGB frame per run over valid/ready.
module led_display_pattern_gen_multi #(
  parameter int SYS_CLK_FREQ   = 12_500_000,
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int BPC            = 8,
  parameter int CHECK_LOG2     = 3,
  localparam int RW = $clog2(NUM_ROW_PIXELS),
  localparam int CW = $clog2(NUM_COL_PIXELS)
) (
  input  logic             clk_in,
  input  logic             n_reset_in,
  input  logic             enable_in,
  input  logic [2:0]       mode_in,
  input  logic [3*BPC-1:0] colour_in,
  output logic [3*BPC-1:0] pixel_data_out,
  output logic [RW-1:0]    pixel_row_out,
  output logic [CW-1:0]    pixel_col_out,
  output logic             pixel_valid_out,
  input  logic             pixel_ready_in,
  output logic             frame_start_out,
  output logic             frame_end_out,
  output logic [15:0]      frame_count_out
);

  if (SYS_CLK_FREQ < 1 || NUM_ROW_PIXELS < 8 ||
      NUM_COL_PIXELS < 8 || BPC < CW || BPC < RW ||
      CHECK_LOG2 >= RW || CHECK_LOG2 >= CW ||
      (1 << RW) != NUM_ROW_PIXELS ||
      (1 << CW) != NUM_COL_PIXELS) begin : g_bad_params
    $error("led_display_pattern_gen_multi: bad parameters");
  end

  localparam logic [RW-1:0] ROW_MAX = RW'(NUM_ROW_PIXELS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(NUM_COL_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]       mode_q;
  logic [3*BPC-1:0] colour_q;
  logic [2:0]       offset_q;
  logic [RW-1:0]    row_nxt;
  logic [CW-1:0]    col_nxt;
  logic             last_nxt;
  logic             xfer;

  function automatic logic [3*BPC-1:0] bar_rgb(
    input logic [2:0] b
  );
    return {{BPC{b[2]}}, {BPC{b[1]}}, {BPC{b[0]}}};
  endfunction

  function automatic logic [3*BPC-1:0] pattern(
    input logic [2:0]       m,
    input logic [3*BPC-1:0] rgb,
    input logic [2:0]       off,
    input logic [RW-1:0]    r,
    input logic [CW-1:0]    c
  );
    logic [BPC-1:0] gr;
    logic [BPC-1:0] gg;
    logic [2:0]     s;
    gr = BPC'(c) << (BPC - CW);
    gg = BPC'(r) << (BPC - RW);
    s  = 3'(r) + 3'(c) + off;
    unique case (m)
      3'd0: return rgb;
      3'd1: return {gr, gg, {BPC{1'b0}}};
      3'd2: return bar_rgb(c[CW-1:CW-3]);
      3'd3: return (r[CHECK_LOG2] ^ c[CHECK_LOG2]) ?
                   rgb : '0;
      3'd4: return bar_rgb(s);
      default: return '0;
    endcase
  endfunction

  assign xfer = pixel_valid_out & pixel_ready_in;

  always_comb begin
    col_nxt = pixel_col_out + 1'b1;
    row_nxt = pixel_row_out;
    if (pixel_col_out == COL_MAX) begin
      col_nxt = '0;
      row_nxt = pixel_row_out + 1'b1;
    end
    last_nxt = (row_nxt == ROW_MAX) &&
               (col_nxt == COL_MAX);
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable_in) state_d = LOAD;
      end
      LOAD: state_d = STREAM;
      STREAM: begin
        if (xfer && frame_end_out)
          state_d = enable_in ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers carry the presented pixel; they move only on transfer.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      mode_q          <= '0;
      colour_q        <= '0;
      offset_q        <= '0;
      pixel_data_out  <= '0;
      pixel_row_out   <= '0;
      pixel_col_out   <= '0;
      pixel_valid_out <= 1'b0;
      frame_start_out <= 1'b0;
      frame_end_out   <= 1'b0;
      frame_count_out <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          mode_q          <= mode_in;
          colour_q        <= colour_in;
          offset_q        <= frame_count_out[2:0];
          pixel_row_out   <= '0;
          pixel_col_out   <= '0;
          pixel_data_out  <= pattern(mode_in, colour_in,
                                     frame_count_out[2:0],
                                     '0, '0);
          pixel_valid_out <= 1'b1;
          frame_start_out <= 1'b1;
          frame_end_out   <= 1'b0;
        end
        STREAM: begin
          if (xfer && frame_end_out) begin
            pixel_valid_out <= 1'b0;
            frame_start_out <= 1'b0;
            frame_end_out   <= 1'b0;
            frame_count_out <= frame_count_out + 16'd1;
          end else if (xfer) begin
            pixel_row_out   <= row_nxt;
            pixel_col_out   <= col_nxt;
            pixel_data_out  <= pattern(mode_q, colour_q,
                                       offset_q,
                                       row_nxt, col_nxt);
            frame_start_out <= 1'b0;
            frame_end_out   <= last_nxt;
          end
        end
        default: begin
          pixel_valid_out <= 1'b0;
          frame_start_out <= 1'b0;
          frame_end_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_pattern_gen_multi.sv
// Scoreboard bench for led_display_pattern_gen_multi.
// Expected pixels are queued at stimulus time, popped on transfer.
module tb_led_display_pattern_gen_multi;

  localparam int R  = 32;
  localparam int C  = 64;
  localparam int RC = R * C;

  logic        clk_in = 1'b0;
  logic        n_reset_in = 1'b0;
  logic        enable_in = 1'b0;
  logic [2:0]  mode_in = '0;
  logic [23:0] colour_in = '0;
  logic [23:0] pixel_data_out;
  logic [4:0]  pixel_row_out;
  logic [5:0]  pixel_col_out;
  logic        pixel_valid_out;
  logic        pixel_ready_in = 1'b0;
  logic        frame_start_out;
  logic        frame_end_out;
  logic [15:0] frame_count_out;

  always #5 clk_in = ~clk_in;

  led_display_pattern_gen_multi dut (
    .clk_in          (clk_in),
    .n_reset_in      (n_reset_in),
    .enable_in       (enable_in),
    .mode_in         (mode_in),
    .colour_in       (colour_in),
    .pixel_data_out  (pixel_data_out),
    .pixel_row_out   (pixel_row_out),
    .pixel_col_out   (pixel_col_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_ready_in  (pixel_ready_in),
    .frame_start_out (frame_start_out),
    .frame_end_out   (frame_end_out),
    .frame_count_out (frame_count_out)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          mcount = 0;
  bit          rnd = 1'b0;
  bit          held_v = 1'b0;
  logic [36:0] held;
  logic [36:0] q[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar(input int b);
    logic [23:0] v;
    v = '0;
    if (b & 4) v[23:16] = 8'hFF;
    if (b & 2) v[15:8]  = 8'hFF;
    if (b & 1) v[7:0]   = 8'hFF;
    return v;
  endfunction

  function automatic logic [23:0] model(input int m,
    input logic [23:0] rgb, input int off,
    input int r, input int c);
    case (m)
      0: return rgb;
      1: return {8'(c * (256 / C)), 8'(r * (256 / R)), 8'h00};
      2: return bar(c / (C / 8));
      3: return (((r / 8) + (c / 8)) % 2 == 1) ? rgb : 24'h0;
      4: return bar((r + c + off) % 8);
      default: return 24'h0;
    endcase
  endfunction

  task automatic push_frame(input int m,
    input logic [23:0] rgb, input int off);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        q.push_back({model(m, rgb, off % 8, r, c),
                     5'(r), 6'(c),
                     1'(r == 0 && c == 0),
                     1'(r == R - 1 && c == C - 1)});
  endtask

  function automatic logic [36:0] obs();
    return {pixel_data_out, pixel_row_out, pixel_col_out,
            frame_start_out, frame_end_out};
  endfunction

  always @(negedge clk_in) begin
    pixel_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!n_reset_in) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("hold", {27'h0, pixel_valid_out, obs()},
                    {27'h0, 1'b1, held});
      held_v = pixel_valid_out && !pixel_ready_in;
      held   = obs();
      if (pixel_valid_out && pixel_ready_in) begin
        if (q.size() == 0) chk("extra", 64'(pixel_valid_out), 64'h0);
        else               chk("pix", 64'(obs()), 64'(q.pop_front()));
      end
    end
  end

  task automatic wait_q(input int tgt);
    int n;
    n = 0;
    while (q.size() > tgt && n < 20000) begin
      @(posedge clk_in); #2;
      n++;
    end
    if (q.size() > tgt) chk("timeout", 64'(q.size()), 64'(tgt));
  endtask

  task automatic finish_run(input int nfr);
    wait_q(RC - 1);
    enable_in = 1'b0;
    wait_q(0);
    repeat (3) @(posedge clk_in);
    #2;
    mcount += nfr;
    chk("count", 64'(frame_count_out), 64'(mcount & 16'hFFFF));
    chk("idle", 64'(pixel_valid_out), 64'h0);
  endtask

  task automatic run(input int m, input logic [23:0] rgb,
                     input int nfr, input bit r);
    rnd       = r;
    mode_in   = 3'(m);
    colour_in = rgb;
    for (int f = 0; f < nfr; f++) push_frame(m, rgb, mcount + f);
    enable_in = 1'b1;
    finish_run(nfr);
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #2;
    chk("rst", {pixel_valid_out, obs(), frame_count_out}, 64'h0);
    n_reset_in = 1'b1;
    @(posedge clk_in); #2;

    run(0, 24'h123456, 1, 1'b0);
    run(1, 24'h000000, 1, 1'b1);
    run(2, 24'h000000, 1, 1'b0);
    run(3, 24'hFF0000, 1, 1'b1);

    // mode change mid-frame only shows up in the next frame
    rnd = 1'b0;
    mode_in = 3'd0;
    colour_in = 24'hABCDEF;
    push_frame(0, 24'hABCDEF, mcount);
    push_frame(2, 24'hABCDEF, mcount + 1);
    enable_in = 1'b1;
    wait_q(2 * RC - 100);
    mode_in = 3'd2;
    finish_run(2);

    rnd = 1'b1;
    mode_in = 3'd3;
    colour_in = 24'h00FF00;
    push_frame(3, 24'h00FF00, mcount);
    enable_in = 1'b1;
    wait_q(RC - 500);
    n_reset_in = 1'b0;
    #1;
    chk("rst_mid", {pixel_valid_out, obs(), frame_count_out}, 64'h0);
    q.delete();
    mcount = 0;
    rnd = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    mode_in = 3'd4;
    for (int f = 0; f < 3; f++) push_frame(4, 24'h0, f);
    n_reset_in = 1'b1;
    @(posedge clk_in); #1;
    chk("lat_load", 64'(pixel_valid_out), 64'h0);
    @(posedge clk_in); #1;
    chk("lat_first", {pixel_valid_out, pixel_row_out, pixel_col_out},
                     {1'b1, 5'd0, 6'd0});
    finish_run(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
